// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the EX-stage hazard controller.
package ex_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Forwarding select for one ALU operand; MEM outranks WB, $zero never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_dst,
    input logic       wb_we,
    input logic [4:0] wb_dst,
    input logic [4:0] src
  );
    if (mem_we && (mem_dst != REG_ZERO) && (mem_dst == src))
      return FWD_MEM;
    else if (wb_we && (wb_dst != REG_ZERO) && (wb_dst == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-side signal bundle between the datapath and the EX hazard controller.
interface ex_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_reg_dst;
  logic             ex_MemRead;
  logic             ex_mdu_start;
  logic             branch_taken;
  logic [4:0]       mem_reg_dst;
  logic             mem_RegWrite;
  logic [4:0]       wb_reg_dst;
  logic             wb_RegWrite;

  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_reg_dst, ex_MemRead, ex_mdu_start,
           branch_taken, mem_reg_dst, mem_RegWrite, wb_reg_dst, wb_RegWrite,
    input  forward_a, forward_b, stall_pc, stall_ifid, stall_idex, bubble_idex,
           flush_ifid, mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_reg_dst, ex_MemRead, ex_mdu_start,
           branch_taken, mem_reg_dst, mem_RegWrite, wb_reg_dst, wb_RegWrite,
    output forward_a, forward_b, stall_pc, stall_ifid, stall_idex, bubble_idex,
           flush_ifid, mdu_busy, mdu_done, stall_cycles
  );

endinterface

// File: rtl/ex_hazard_ctrl_mdu_seq.sv
// MULT/DIV occupancy sequencer: IDLE -> BUSY -> DONE -> IDLE.
module mdu_seq
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic mdu_idle,
  output logic mdu_busy,
  output logic mdu_done,
  output logic mdu_freeze
);

  localparam logic [7:0] CNT_LOAD = 8'(MDU_LATENCY - 2);

  mdu_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: BUSY lasts MDU_LATENCY-2 cycles, so together with the start
  // cycle and DONE the op occupies EX for exactly MDU_LATENCY cycles. The exit
  // is taken as the counter steps down to zero; a load of zero skips BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1)
          state_d = MDU_DONE;
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  // Status outputs; forced quiet while reset is held.
  always_comb begin
    mdu_idle   = reset && (state_q == MDU_IDLE);
    mdu_busy   = reset && (state_q == MDU_BUSY);
    mdu_done   = reset && (state_q == MDU_DONE);
    mdu_freeze = mdu_busy || (mdu_idle && start);
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding, load-use bubble, branch flush,
// MDU freeze and a saturating stall-cycle counter.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic           clk,
  input  logic           reset,
  ex_hazard_ctrl_if.slave hz
);

  logic             mdu_start;
  logic             mdu_idle;
  logic             mdu_busy;
  logic             mdu_done;
  logic             mdu_freeze;
  logic             lu;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             bubble_idex;
  logic             flush_ifid;
  logic [CNT_W-1:0] cnt_q;

  // A taken branch squashes a same-cycle MDU start (wrong-path op).
  always_comb begin
    mdu_start = hz.ex_mdu_start && !hz.branch_taken;
  end

  mdu_seq #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (mdu_start),
    .mdu_idle   (mdu_idle),
    .mdu_busy   (mdu_busy),
    .mdu_done   (mdu_done),
    .mdu_freeze (mdu_freeze)
  );

  // Forwarding and stall priority: MDU freeze, then branch flush, then load-use.
  always_comb begin
    fwd_a       = FWD_REG;
    fwd_b       = FWD_REG;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    lu          = hz.ex_MemRead && (hz.ex_reg_dst != REG_ZERO) &&
                  ((hz.ex_reg_dst == hz.id_rs) || (hz.ex_reg_dst == hz.id_rt));
    if (reset) begin
      fwd_a = fwd_sel(hz.mem_RegWrite, hz.mem_reg_dst, hz.wb_RegWrite, hz.wb_reg_dst, hz.ex_rs);
      fwd_b = fwd_sel(hz.mem_RegWrite, hz.mem_reg_dst, hz.wb_RegWrite, hz.wb_reg_dst, hz.ex_rt);
      if (mdu_freeze) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
      end else if (mdu_idle && hz.branch_taken) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (lu) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if (stall_pc && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  // Drive the interface.
  always_comb begin
    hz.forward_a    = fwd_a;
    hz.forward_b    = fwd_b;
    hz.stall_pc     = stall_pc;
    hz.stall_ifid   = stall_ifid;
    hz.stall_idex   = stall_idex;
    hz.bubble_idex  = bubble_idex;
    hz.flush_ifid   = flush_ifid;
    hz.mdu_busy     = mdu_busy;
    hz.mdu_done     = mdu_done;
    hz.stall_cycles = cnt_q;
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed, table-driven bench for ex_hazard_ctrl.
module tb_ex_hazard_ctrl;

  logic clk;
  logic reset;

  int pass_cnt;
  int total_cnt;
  int exp_cnt;

  ex_hazard_ctrl_if #(.CNT_W(32)) hz4 ();
  ex_hazard_ctrl_if #(.CNT_W(4))  hzs ();

  ex_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz4.slave)
  );

  ex_hazard_ctrl #(.MDU_LATENCY(32), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .hz    (hzs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] mem_dst;
    logic       mem_we;
    logic [4:0] wb_dst;
    logic       wb_we;
    logic       ld;
    logic [4:0] ld_dst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       spc;
    logic       sif;
    logic       bub;
    logic       fl;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz4.id_rs = '0; hz4.id_rt = '0; hz4.ex_rs = '0; hz4.ex_rt = '0;
    hz4.ex_reg_dst = '0; hz4.ex_MemRead = 1'b0; hz4.ex_mdu_start = 1'b0;
    hz4.branch_taken = 1'b0; hz4.mem_reg_dst = '0; hz4.mem_RegWrite = 1'b0;
    hz4.wb_reg_dst = '0; hz4.wb_RegWrite = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hz4.ex_rs = v.ex_rs; hz4.ex_rt = v.ex_rt;
    hz4.mem_reg_dst = v.mem_dst; hz4.mem_RegWrite = v.mem_we;
    hz4.wb_reg_dst = v.wb_dst; hz4.wb_RegWrite = v.wb_we;
    hz4.ex_MemRead = v.ld; hz4.ex_reg_dst = v.ld_dst;
    hz4.id_rs = v.id_rs; hz4.id_rt = v.id_rt;
    hz4.branch_taken = v.br; hz4.ex_mdu_start = 1'b0;
  endtask

  task automatic set_lu();
    hz4.ex_MemRead = 1'b1; hz4.ex_reg_dst = 5'd9; hz4.id_rt = 5'd9;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; exp_cnt = 0;
    // ex_rs ex_rt mdst mwe wdst wwe ld lddst idrs idrt br  fa fb spc sif bub fl
    vecs[0]  = '{5'd8,  5'd3,  5'd8,  1'b1, 5'd8,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd8,  5'd3,  5'd8,  1'b0, 5'd8,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd5,  5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd6,  5'd7,  5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd6,  5'd7,  5'd6,  1'b0, 5'd7,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd9,  5'd4,  5'd9, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd9,  5'd9,  5'd4, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd9,  5'd9,  5'd9, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd9,  5'd4,  5'd9, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd1,  5'd2, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{5'd12, 5'd13, 5'd12, 1'b1, 5'd13, 1'b1, 1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{5'd4,  5'd4,  5'd3,  1'b1, 5'd4,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};

    hzs.id_rs = '0; hzs.id_rt = '0; hzs.ex_rs = '0; hzs.ex_rt = '0;
    hzs.ex_reg_dst = '0; hzs.ex_MemRead = 1'b0; hzs.ex_mdu_start = 1'b0;
    hzs.branch_taken = 1'b0; hzs.mem_reg_dst = '0; hzs.mem_RegWrite = 1'b0;
    hzs.wb_reg_dst = '0; hzs.wb_RegWrite = 1'b0;

    // Reset: outputs quiet regardless of inputs.
    reset = 1'b0;
    apply(vecs[12]);
    hz4.ex_mdu_start = 1'b1;
    @(negedge clk);
    chk("rst_fa", 32'(hz4.forward_a), 32'd0);
    chk("rst_fb", 32'(hz4.forward_b), 32'd0);
    chk("rst_stall_pc", 32'(hz4.stall_pc), 32'd0);
    chk("rst_stall_idex", 32'(hz4.stall_idex), 32'd0);
    chk("rst_bubble", 32'(hz4.bubble_idex), 32'd0);
    next_cycle();
    next_cycle();
    hz4.branch_taken = 1'b1;
    @(negedge clk);
    chk("rst_flush", 32'(hz4.flush_ifid), 32'd0);
    chk("rst_cnt", hz4.stall_cycles, 32'd0);
    chk("rst_busy", 32'(hz4.mdu_busy), 32'd0);
    clr();
    reset = 1'b1;
    next_cycle();

    // Combinational table in IDLE.
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_fa", i), 32'(hz4.forward_a), 32'(vecs[i].fa));
      chk($sformatf("v%0d_fb", i), 32'(hz4.forward_b), 32'(vecs[i].fb));
      chk($sformatf("v%0d_stall_pc", i), 32'(hz4.stall_pc), 32'(vecs[i].spc));
      chk($sformatf("v%0d_stall_ifid", i), 32'(hz4.stall_ifid), 32'(vecs[i].sif));
      chk($sformatf("v%0d_stall_idex", i), 32'(hz4.stall_idex), 32'd0);
      chk($sformatf("v%0d_bubble", i), 32'(hz4.bubble_idex), 32'(vecs[i].bub));
      chk($sformatf("v%0d_flush", i), 32'(hz4.flush_ifid), 32'(vecs[i].fl));
      chk($sformatf("v%0d_cnt", i), hz4.stall_cycles, 32'(exp_cnt));
      if (vecs[i].spc) exp_cnt++;
      next_cycle();
    end

    // MDU op, latency 4: start, BUSY, BUSY, DONE, IDLE.
    clr();
    hz4.ex_mdu_start = 1'b1;
    @(negedge clk);
    chk("mdu0_stall_pc", 32'(hz4.stall_pc), 32'd1);
    chk("mdu0_stall_ifid", 32'(hz4.stall_ifid), 32'd1);
    chk("mdu0_stall_idex", 32'(hz4.stall_idex), 32'd1);
    chk("mdu0_bubble", 32'(hz4.bubble_idex), 32'd0);
    chk("mdu0_busy", 32'(hz4.mdu_busy), 32'd0);
    chk("mdu0_done", 32'(hz4.mdu_done), 32'd0);
    exp_cnt++;
    next_cycle();
    hz4.branch_taken = 1'b1;
    set_lu();
    @(negedge clk);
    chk("mdu1_stall_pc", 32'(hz4.stall_pc), 32'd1);
    chk("mdu1_stall_idex", 32'(hz4.stall_idex), 32'd1);
    chk("mdu1_bubble", 32'(hz4.bubble_idex), 32'd0);
    chk("mdu1_flush", 32'(hz4.flush_ifid), 32'd0);
    chk("mdu1_busy", 32'(hz4.mdu_busy), 32'd1);
    chk("mdu1_done", 32'(hz4.mdu_done), 32'd0);
    exp_cnt++;
    next_cycle();
    clr();
    @(negedge clk);
    chk("mdu2_stall_pc", 32'(hz4.stall_pc), 32'd1);
    chk("mdu2_busy", 32'(hz4.mdu_busy), 32'd1);
    chk("mdu2_done", 32'(hz4.mdu_done), 32'd0);
    exp_cnt++;
    next_cycle();
    set_lu();
    hz4.ex_mdu_start = 1'b1;
    hz4.branch_taken = 1'b1;
    @(negedge clk);
    chk("mdu3_done", 32'(hz4.mdu_done), 32'd1);
    chk("mdu3_busy", 32'(hz4.mdu_busy), 32'd0);
    chk("mdu3_stall_pc", 32'(hz4.stall_pc), 32'd1);
    chk("mdu3_stall_idex", 32'(hz4.stall_idex), 32'd0);
    chk("mdu3_bubble", 32'(hz4.bubble_idex), 32'd1);
    chk("mdu3_flush", 32'(hz4.flush_ifid), 32'd0);
    exp_cnt++;
    next_cycle();
    clr();
    @(negedge clk);
    chk("mdu4_done", 32'(hz4.mdu_done), 32'd0);
    chk("mdu4_busy", 32'(hz4.mdu_busy), 32'd0);
    chk("mdu4_stall_pc", 32'(hz4.stall_pc), 32'd0);
    chk("mdu4_cnt", hz4.stall_cycles, 32'(exp_cnt));
    next_cycle();

    // Start and taken branch together: flush wins, FSM stays idle.
    hz4.ex_mdu_start = 1'b1;
    hz4.branch_taken = 1'b1;
    @(negedge clk);
    chk("sb_flush", 32'(hz4.flush_ifid), 32'd1);
    chk("sb_bubble", 32'(hz4.bubble_idex), 32'd1);
    chk("sb_stall_pc", 32'(hz4.stall_pc), 32'd0);
    chk("sb_stall_idex", 32'(hz4.stall_idex), 32'd0);
    next_cycle();
    clr();
    @(negedge clk);
    chk("sb_busy", 32'(hz4.mdu_busy), 32'd0);
    chk("sb_stall_after", 32'(hz4.stall_pc), 32'd0);
    next_cycle();

    // Reset while BUSY.
    hz4.ex_mdu_start = 1'b1;
    next_cycle();
    clr();
    @(negedge clk);
    chk("rb_busy", 32'(hz4.mdu_busy), 32'd1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rb_stall_pc", 32'(hz4.stall_pc), 32'd0);
    chk("rb_stall_idex", 32'(hz4.stall_idex), 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rb_idle_busy", 32'(hz4.mdu_busy), 32'd0);
    chk("rb_idle_done", 32'(hz4.mdu_done), 32'd0);
    chk("rb_idle_stall", 32'(hz4.stall_pc), 32'd0);
    chk("rb_cnt", hz4.stall_cycles, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rb_no_done", 32'(hz4.mdu_done), 32'd0);
    next_cycle();

    // Saturation with a 4-bit counter during a long MDU freeze.
    hzs.ex_mdu_start = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 1) hzs.ex_mdu_start = 1'b0;
      @(negedge clk);
      if (k == 14) chk("sat_14", 32'(hzs.stall_cycles), 32'd14);
      if (k == 15) chk("sat_15", 32'(hzs.stall_cycles), 32'd15);
      if (k == 16) chk("sat_16", 32'(hzs.stall_cycles), 32'd15);
      if (k == 20) begin
        chk("sat_20", 32'(hzs.stall_cycles), 32'd15);
        chk("sat_busy", 32'(hzs.mdu_busy), 32'd1);
        chk("sat_stall", 32'(hzs.stall_pc), 32'd1);
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
